// File: rtl/sobel_pkg.sv
// Sobel window reader: shared package.
// States, window index constants and index helpers.
package sobel_pkg;

  localparam int WIN_N = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] P0 = 4'd0;
  localparam logic [3:0] P1 = 4'd1;
  localparam logic [3:0] P2 = 4'd2;
  localparam logic [3:0] P3 = 4'd3;
  localparam logic [3:0] P4 = 4'd4;
  localparam logic [3:0] P5 = 4'd5;
  localparam logic [3:0] P6 = 4'd6;
  localparam logic [3:0] P7 = 4'd7;
  localparam logic [3:0] P8 = 4'd8;

  function automatic logic [1:0] row_of(input logic [3:0] k);
    logic [1:0] r;
    r = 2'd2;
    if (k <= P2) r = 2'd0;
    else if (k <= P5) r = 2'd1;
    return r;
  endfunction

  function automatic logic [1:0] col_of(input logic [3:0] k);
    logic [1:0] c;
    c = 2'd2;
    if (k == P0 || k == P3 || k == P6) c = 2'd0;
    else if (k == P1 || k == P4 || k == P7) c = 2'd1;
    return c;
  endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Sobel window reader: centre counters and
// frame-buffer address for a window element.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int AW    = 5,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [3:0]    i_idx,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_ctr,
  output logic          o_wrap,
  output logic          o_last
);

  logic [AW-1:0] r_x;
  logic [AW-1:0] r_y;
  logic [AW-1:0] w_r;
  logic [AW-1:0] w_c;

  assign o_wrap = (r_x == AW'(IMG_W-2));
  assign o_last = o_wrap && (r_y == AW'(IMG_H-2));

  assign w_r = AW'(row_of(i_idx));
  assign w_c = AW'(col_of(i_idx));

  assign o_addr = (r_y + w_r - AW'(1)) * AW'(IMG_W)
                + (r_x + w_c - AW'(1));
  assign o_ctr  = r_y * AW'(IMG_W) + r_x;

  // Raster-scan the interior centres.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x <= AW'(1);
      r_y <= AW'(1);
    end else if (i_clr) begin
      r_x <= AW'(1);
      r_y <= AW'(1);
    end else if (i_adv) begin
      if (o_wrap) begin
        r_x <= AW'(1);
        r_y <= o_last ? AW'(1) : r_y + AW'(1);
      end else begin
        r_x <= r_x + AW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_reader.sv
// Sobel window reader: fetches 3x3 windows.
// Column reuse when SOBEL_WIN_REUSE_EN is defined.
module sobel_window_reader
  import sobel_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DW    = 4,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rw,
  input  logic [DW-1:0]   mem_data,
  output logic [9*DW-1:0] win,
  output logic [AW-1:0]   win_addr,
  output logic            win_valid,
  input  logic            win_ready,
  output logic            busy,
  output logic            done
);

`ifdef SOBEL_WIN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic [2:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_reuse;
  logic          r_cap_en;
  logic [3:0]    r_cap_idx;
  logic [DW-1:0] r_win [WIN_N];
  logic [AW-1:0] r_win_addr;

  logic [3:0]    w_widx;
  logic [3:0]    w_nlast;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_ctr;
  logic          w_wrap;
  logic          w_last;
  logic          w_hs;
  logic          w_shift;

  assign w_hs      = (r_state == S_HOLD) && win_ready;
  assign w_shift   = w_hs && REUSE && !w_wrap;
  assign w_nlast   = r_reuse ? 4'd2 : 4'd8;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign win_valid = (r_state == S_HOLD);
  assign mem_rw    = (r_state == S_FETCH) ||
                     (r_state == S_DRAIN) ||
                     (r_state == S_HOLD);
  assign mem_addr  = mem_rw ? w_addr : '0;
  assign win_addr  = r_win_addr;

  sobel_addr_gen #(
    .AW    (AW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  ((r_state == S_IDLE) && start),
    .i_adv  (w_hs),
    .i_idx  (w_widx),
    .o_addr (w_addr),
    .o_ctr  (w_ctr),
    .o_wrap (w_wrap),
    .o_last (w_last)
  );

  // Window element addressed by the fetch count.
  always_comb begin
    w_widx = r_cnt;
    if (r_reuse) begin
      unique case (r_cnt)
        4'd0:    w_widx = P2;
        4'd1:    w_widx = P5;
        default: w_widx = P8;
      endcase
    end
  end

  // Scan control FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_reuse    <= 1'b0;
      r_win_addr <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
          r_reuse <= 1'b0;
        end
        S_FETCH: begin
          if (r_cnt == w_nlast) r_state <= S_DRAIN;
          else r_cnt <= r_cnt + 4'd1;
        end
        S_DRAIN: begin
          r_state    <= S_HOLD;
          r_win_addr <= w_ctr;
        end
        S_HOLD: if (win_ready) begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_reuse <= REUSE && !w_wrap;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data lags its address by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_cap_en  <= (r_state == S_FETCH);
      r_cap_idx <= w_widx;
    end
  end

  // Capture read data, or slide columns left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < WIN_N; k++) r_win[k] <= '0;
    end else if (r_cap_en) begin
      r_win[r_cap_idx] <= mem_data;
    end else if (w_shift) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
      end
    end
  end

  // Flatten window, p0 in the LSBs.
  always_comb begin
    win = '0;
    for (int k = 0; k < WIN_N; k++)
      win[k*DW +: DW] = r_win[k];
  end

endmodule

// File: tb/tb_sobel_window_reader.sv
// Directed bench for sobel_window_reader, 4x4 frame,
// RAM[i]=i; honours SOBEL_WIN_REUSE_EN.
module tb_sobel_window_reader;

  localparam int AW = 5;
  localparam int DW = 4;

`ifdef SOBEL_WIN_REUSE_EN
  localparam int LAT2 = 5;
  localparam int FA2  = 3;
`else
  localparam int LAT2 = 11;
  localparam int FA2  = 1;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [AW-1:0]   mem_addr;
  logic            mem_rw;
  logic [DW-1:0]   mem_data;
  logic [9*DW-1:0] win;
  logic [AW-1:0]   win_addr;
  logic            win_valid;
  logic            win_ready;
  logic            busy;
  logic            done;

  logic [DW-1:0]   ram [32];
  int              n_chk = 0;
  int              n_fail = 0;
  int              first_addr;
  int              ctrs [4] = '{5, 6, 9, 10};

  always #5 clk = ~clk;

  sobel_window_reader #(
    .AW(AW), .DW(DW), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_data(mem_data), .win(win),
    .win_addr(win_addr), .win_valid(win_valid),
    .win_ready(win_ready), .busy(busy), .done(done)
  );

  always @(posedge clk) mem_data <= ram[mem_addr];

  function automatic logic [35:0] exp_win(input int c);
    logic [35:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      v = c + (k / 3 - 1) * 4 + (k % 3 - 1);
      r[k*4 +: 4] = v[3:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One edge at least, then up to 40 for win_valid.
  task automatic go_wait(input string tag,
                         input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) first_addr = int'(mem_addr);
      start = 1'b0;
      win_ready = 1'b0;
    end while (!win_valid && n < 40);
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win"},   64'(win), 64'd0);
    chk({tag, "_waddr"}, 64'(win_addr), 64'd0);
    chk({tag, "_valid"}, 64'(win_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_rw"},    64'(mem_rw), 64'd0);
  endtask

  initial begin
    bit ok;
    bit early;
    int k;
    for (int i = 0; i < 32; i++) ram[i] = 4'(i);
    rstn = 1'b0;
    start = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // First window: full fetch.
    start = 1'b1;
    go_wait("lat_first", 11);
    chk("first_addr", 64'(first_addr), 64'd0);
    chk("w1_addr", 64'(win_addr), 64'd5);
    chk("w1_win", 64'(win), 64'(exp_win(5)));
    chk("w1_rw", 64'(mem_rw), 64'd1);

    // Stall 20 cycles with start noise.
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      @(posedge clk); #1;
      ok &= win_valid && busy
         && (win == exp_win(5))
         && (win_addr == 5'd5)
         && (mem_addr == 5'd10);
    end
    start = 1'b0;
    chk("hold_stable", 64'(ok), 64'd1);

    // Second window latency.
    win_ready = 1'b1;
    go_wait("lat_second", LAT2);
    chk("w2_first_addr", 64'(first_addr), 64'(FA2));
    chk("w2_addr", 64'(win_addr), 64'd6);
    chk("w2_win", 64'(win), 64'(exp_win(6)));

    // Rest of frame, ready held, start noise.
    k = 2;
    early = 1'b0;
    win_ready = 1'b1;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(posedge clk); #1;
      if (done) early = 1'b1;
      if (win_valid) begin
        chk("scan_addr", 64'(win_addr), 64'(ctrs[k]));
        chk("scan_win", 64'(win), 64'(exp_win(ctrs[k])));
        k++;
        start = 1'b0;
      end else begin
        start = 1'b1;
      end
    end
    chk("scan_count", 64'(k), 64'd4);
    chk("no_early_done", 64'(early), 64'd0);
    @(posedge clk); #1;
    win_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rw", 64'(mem_rw), 64'd0);

    // Reset in FETCH of second window.
    start = 1'b1;
    go_wait("lat_rescan", 11);
    chk("rescan_addr", 64'(win_addr), 64'd5);
    win_ready = 1'b1;
    @(posedge clk); #1;
    win_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_fetch_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    go_wait("lat_after_rst", 11);
    chk("after_rst_addr", 64'(win_addr), 64'd5);
    chk("after_rst_win", 64'(win), 64'(exp_win(5)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
